seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_driver_hex_to_7seg.sv | 11 +
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constant tables for the four-digit seven-segment scan driver.
// Segment patterns are active-high with bit 0 = a through bit 6 = g.
package seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [3:0] DIGIT_EN_ONEHOT [NUM_DIGITS] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000
   };

endpackage

// File: rtl/seg7_scan_driver_hex_to_7seg.sv
// Combinational nibble to active-high seven-segment pattern (a in bit 0).
module hex_to_7seg
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: double-buffered digit data,
// per-digit BLANK/DRIVE slots, registered outputs with selectable polarity.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int REFRESH_HZ     = 1000,
   parameter int BLANK_CYCLES   = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  ds_en,
   output logic        frame_done
);

   // BLANK_CYCLES is expected to be at least 1 and below DIGIT_CYCLES.
   localparam int DIGIT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int CNT_W        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [3:0] EN_OFF  = {4{EN_ACTIVE_LOW}};

   scan_state_t      r_state;
   scan_state_t      w_state_nxt;
   logic             w_idx_adv;
   logic [CNT_W-1:0] r_slot;
   logic [1:0]       r_idx;
   logic             w_frame_end;

   logic [15:0] r_shd_digits;
   logic [3:0]  r_shd_dp;
   logic [3:0]  r_shd_blank;
   logic [15:0] r_act_digits;
   logic [3:0]  r_act_dp;
   logic [3:0]  r_act_blank;

   logic [3:0] w_nibble;
   logic [6:0] w_seg_hex;
   logic       w_show;
   logic       w_lit;
   logic [6:0] w_seg_nxt;
   logic       w_dp_nxt;
   logic [3:0] w_en_nxt;

   logic [6:0] r_seg;
   logic       r_dp;
   logic [3:0] r_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else if (r_slot == CNT_LAST) begin
         r_slot <= '0;
      end else begin
         r_slot <= r_slot + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BLANK;
         r_idx   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_idx_adv) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_adv   = 1'b0;
      case (r_state)
         BLANK: begin
            if (r_slot == BLANK_LAST) begin
               w_state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (r_slot == CNT_LAST) begin
               w_state_nxt = BLANK;
               w_idx_adv   = 1'b1;
            end
         end
         default: w_state_nxt = BLANK;
      endcase
   end

   assign w_frame_end = (r_slot == CNT_LAST) && (r_idx == 2'd3);
   assign frame_done  = w_frame_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shd_digits <= '0;
         r_shd_dp     <= '0;
         r_shd_blank  <= 4'b1111;
      end else if (load) begin
         r_shd_digits <= digits_in;
         r_shd_dp     <= dp_in;
         r_shd_blank  <= blank_in;
      end
   end

   // A load landing on the boundary cycle bypasses the shadow so it is not lost for a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_digits <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= 4'b1111;
      end else if (w_frame_end) begin
         r_act_digits <= load ? digits_in : r_shd_digits;
         r_act_dp     <= load ? dp_in     : r_shd_dp;
         r_act_blank  <= load ? blank_in  : r_shd_blank;
      end
   end

   assign w_nibble = r_act_digits[{r_idx, 2'b00} +: 4];

   hex_to_7seg u_hex_to_7seg (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_hex)
   );

   // Blanked digits keep their enable so every slot has identical timing.
   assign w_show    = (r_state == DRIVE);
   assign w_lit     = w_show && !r_act_blank[r_idx];
   assign w_seg_nxt = w_lit ? w_seg_hex : 7'h00;
   assign w_dp_nxt  = w_lit && r_act_dp[r_idx];
   assign w_en_nxt  = w_show ? DIGIT_EN_ONEHOT[r_idx] : 4'b0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
         r_en  <= EN_OFF;
      end else begin
         r_seg <= SEG_OFF ^ w_seg_nxt;
         r_dp  <= DP_OFF ^ w_dp_nxt;
         r_en  <= EN_OFF ^ w_en_nxt;
      end
   end

   assign seg   = r_seg;
   assign dp    = r_dp;
   assign ds_en = r_en;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Frame-level checks of seg7_scan_driver with a 10-cycle digit slot (2 blank, 8 drive).
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  ds_en;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  dpv;
      logic [3:0]  bl;
   } ld_t;

   // One record per displayed frame: up to two loads issued during it, and the
   // per-digit pattern (digit 0 in the low bits) expected while it is shown.
   typedef struct {
      string       name;
      int          ja;
      ld_t         la;
      int          jb;
      ld_t         lb;
      logic [27:0] exp_seg;
      logic [3:0]  exp_dp;
   } frame_vec_t;

   frame_vec_t vecs [6];

   seg7_scan_driver #(
      .CLK_HZ         (400),
      .REFRESH_HZ     (10),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b0),
      .EN_ACTIVE_LOW  (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .seg        (seg),
      .dp         (dp),
      .ds_en      (ds_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic ld_t mk_ld(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
      ld_t l;
      l.d   = d;
      l.dpv = dpv;
      l.bl  = bl;
      return l;
   endfunction

   task automatic set_vec(input int idx, input string name, input int ja, input ld_t la,
                          input int jb, input ld_t lb, input logic [27:0] es, input logic [3:0] ed);
      vecs[idx].name    = name;
      vecs[idx].ja      = ja;
      vecs[idx].la      = la;
      vecs[idx].jb      = jb;
      vecs[idx].lb      = lb;
      vecs[idx].exp_seg = es;
      vecs[idx].exp_dp  = ed;
   endtask

   task automatic drive_load(input ld_t l);
      load      = 1'b1;
      digits_in = l.d;
      dp_in     = l.dpv;
      blank_in  = l.bl;
   endtask

   task automatic check_dark(input string name);
      n_checks++;
      if ({seg, dp, ds_en, frame_done} !== 13'b0) begin
         n_fail++;
         $display("FAIL %s got seg=%h dp=%b en=%b fd=%b want all zero", name, seg, dp, ds_en, frame_done);
      end
   endtask

   // Bounded search for frame_done, then step one cycle so the next
   // check_frame starts aligned with the first output of the new frame.
   task automatic sync_frame(input string name);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s got no frame_done within 100 cycles want frame_done=1", name);
      end
      @(negedge clk);
   endtask

   // Output at step j reflects scan position j (registered one cycle late);
   // frame_done is seen at j=38, the last scan cycle of this frame.
   task automatic check_frame(input frame_vec_t v);
      int         k;
      bit         drv;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_en;
      logic       e_fd;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         k     = j / 10;
         drv   = (j % 10) >= 2;
         e_en  = drv ? (4'b0001 << k) : 4'b0000;
         e_seg = drv ? v.exp_seg[k*7 +: 7] : 7'h00;
         e_dp  = drv ? v.exp_dp[k] : 1'b0;
         e_fd  = (j == 38);
         n_checks++;
         if ({seg, dp, ds_en, frame_done} !== {e_seg, e_dp, e_en, e_fd}) begin
            n_fail++;
            $display("FAIL %s j=%0d got seg=%h dp=%b en=%b fd=%b want seg=%h dp=%b en=%b fd=%b",
                     v.name, j, seg, dp, ds_en, frame_done, e_seg, e_dp, e_en, e_fd);
         end
         load = 1'b0;
         if (j == v.ja) drive_load(v.la);
         if (j == v.jb) drive_load(v.lb);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_vec(0, "dark_after_reset", 20, mk_ld(16'h3210, 4'h0, 4'h0), -1, mk_ld(16'h0, 4'h0, 4'h0),
              28'h0, 4'h0);
      set_vec(1, "digits_3210", 15, mk_ld(16'hABCD, 4'h0, 4'h0), -1, mk_ld(16'h0, 4'h0, 4'h0),
              {7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0);
      set_vec(2, "digits_abcd", 10, mk_ld(16'h1234, 4'h0, 4'h0), 38, mk_ld(16'hFFFF, 4'h0, 4'h0),
              {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'h0);
      set_vec(3, "boundary_ffff", 5, mk_ld(16'h0000, 4'hF, 4'h0), 6, mk_ld(16'h7654, 4'b0001, 4'b1010),
              {7'h71, 7'h71, 7'h71, 7'h71}, 4'h0);
      set_vec(4, "blank_dp", -1, mk_ld(16'h0, 4'h0, 4'h0), -1, mk_ld(16'h0, 4'h0, 4'h0),
              {7'h00, 7'h7D, 7'h00, 7'h66}, 4'b0001);
      set_vec(5, "dark_after_midreset", -1, mk_ld(16'h0, 4'h0, 4'h0), -1, mk_ld(16'h0, 4'h0, 4'h0),
              28'h0, 4'h0);

      rst_n     = 1'b0;
      load      = 1'b0;
      digits_in = 16'h0;
      dp_in     = 4'h0;
      blank_in  = 4'h0;
      repeat (3) @(negedge clk);
      check_dark("reset_state");
      rst_n = 1'b1;

      sync_frame("first_frame_done");
      for (int i = 0; i < 5; i++) begin
         check_frame(vecs[i]);
      end

      // Reset asserted between clock edges while digit 2 is driven.
      repeat (24) @(negedge clk);
      n_checks++;
      if ({seg, ds_en} !== {7'h7D, 4'b0100}) begin
         n_fail++;
         $display("FAIL pre_reset_digit2 got seg=%h en=%b want seg=7d en=0100", seg, ds_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_dark("async_reset_no_clock");
      @(negedge clk);
      check_dark("held_in_reset");
      rst_n = 1'b1;
      sync_frame("frame_done_after_midreset");
      check_frame(vecs[5]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
